ifetch_queue: RTL

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues PC reads, queues returning words for decode.
// Optional same-cycle bypass when built with IFQ_BYPASS_EN defined.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   valid_i/ready_o upstream PC handshake; pc_i is the PC to fetch
//   valid_o/ready_i downstream handshake; pc_o/inst_o/misalign_o head entry
//   insmemaddr_o    memory address (pc_i), insmemreq_o read enable
//   insmemdata_i    read data, valid one cycle after insmemreq_o
//   flush_i         redirect: drops queued and in-flight fetches
module ifetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] insmemaddr_o,
  output logic            insmemreq_o,
  input  logic [XLEN-1:0] insmemdata_i,
  input  logic            flush_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          inflight;
  logic [XLEN-1:0] if_pc;
  logic          if_mis;

  logic [DEPTH-1:0][XLEN-1:0] q_pc;
  logic [DEPTH-1:0][XLEN-1:0] q_inst;
  logic [DEPTH-1:0]           q_mis;

  logic [CW:0] occ;
  logic        nonempty;
  logic        wr;
  logic        pop;

  // In-flight request reserves a slot so its response always fits.
  assign occ = {1'b0, count} + (CW+1)'(inflight);
  assign ready_o = (occ < DEPTH_C) | flush_i;
  assign insmemreq_o = valid_i & ready_o;
  assign insmemaddr_o = pc_i;

  assign nonempty = (count != '0);
  assign pop = nonempty & ready_i & ~flush_i;

`ifdef IFQ_BYPASS_EN
  logic byp;

  // Empty queue: hand the response straight to decode.
  assign byp = ~nonempty & inflight & ~flush_i;
  assign wr = inflight & ~flush_i & ~(byp & ready_i);
  assign valid_o = nonempty | byp;
  assign pc_o = byp ? if_pc : q_pc[head];
  assign inst_o = byp ? insmemdata_i : q_inst[head];
  assign misalign_o = byp ? if_mis : q_mis[head];
`else
  assign wr = inflight & ~flush_i;
  assign valid_o = nonempty;
  assign pc_o = q_pc[head];
  assign inst_o = q_inst[head];
  assign misalign_o = q_mis[head];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
      if_pc    <= '0;
      if_mis   <= 1'b0;
      q_pc     <= '0;
      q_inst   <= '0;
      q_mis    <= '0;
    end else begin
      // A fetch accepted during flush is issued but its result dropped.
      inflight <= insmemreq_o & ~flush_i;
      if (insmemreq_o) begin
        if_pc  <= pc_i;
        if_mis <= (pc_i[1:0] != 2'b00);
      end
      if (flush_i) begin
        count <= '0;
        head  <= tail;
      end else begin
        if (wr) begin
          q_pc[tail]   <= if_pc;
          q_inst[tail] <= insmemdata_i;
          q_mis[tail]  <= if_mis;
          tail         <= tail + AW'(1);
        end
        if (pop) begin
          head <= head + AW'(1);
        end
        unique case ({wr, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule
